// File: rtl/cache_bus_mem_pkg.sv
// Shared types and constants for the 2-beat cache line bus responder.
package cache_bus_pkg;

  localparam int LINE_BITS = 128;
  localparam int BEAT_BITS = 64;
  localparam int ADDR_BITS = 64;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_BEAT0 = 2'd2,
    R_BEAT1 = 2'd3
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_BEAT1 = 2'd1,
    W_RESP  = 2'd2
  } w_state_e;

  // Strip the byte-within-line offset; the caller truncates to its index width,
  // so address bits above the index simply alias.
  function automatic logic [ADDR_BITS-1:0] line_of(input logic [ADDR_BITS-1:0] addr);
    return addr >> 4;
  endfunction

endpackage

// File: rtl/cache_bus_mem_if.sv
// Cache line bus between the data cache (master) and memory (slave).
//
// Handshakes:
//   R: the cache holds r_valid high for the whole refill. r_ready is a
//      beat strobe from memory; a beat transfers when r_valid & r_ready.
//      r_bits_rlast marks the second beat and is only high with r_ready.
//      Dropping r_valid before the last beat aborts the refill.
//   W: a beat transfers when w_valid & w_ready; beat 0 carries the address
//      and the low half, beat 1 the high half.
//   B: the write response transfers when b_valid & b_ready; b_valid holds
//      until accepted.
interface cache_bus_mem_if;
  logic        r_valid;
  logic [63:0] r_bits_raddr;
  logic        r_ready;
  logic [63:0] r_bits_rdata;
  logic        r_bits_rlast;
  logic        w_valid;
  logic [63:0] w_bits_waddr;
  logic [63:0] w_bits_wdata;
  logic        w_bits_wlast;
  logic        w_ready;
  logic        b_ready;
  logic        b_valid;

  modport master (
    output r_valid, r_bits_raddr, w_valid, w_bits_waddr, w_bits_wdata, w_bits_wlast, b_ready,
    input  r_ready, r_bits_rdata, r_bits_rlast, w_ready, b_valid
  );

  modport slave (
    input  r_valid, r_bits_raddr, w_valid, w_bits_waddr, w_bits_wdata, w_bits_wlast, b_ready,
    output r_ready, r_bits_rdata, r_bits_rlast, w_ready, b_valid
  );
endinterface

// File: rtl/cache_bus_mem_array.sv
// Line storage: one synchronous write port with per-half enables and an
// asynchronous read port, so a same-edge read/write of a line sees old data.
module cache_bus_mem_array
  import cache_bus_pkg::*;
#(
  parameter int LINE_AW = 10
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [1:0]           hen_i,
  input  logic [LINE_AW-1:0]   widx_i,
  input  logic [LINE_BITS-1:0] wline_i,
  input  logic [LINE_AW-1:0]   ridx_i,
  output logic [LINE_BITS-1:0] rline_o
);

  logic [LINE_BITS-1:0] mem_q [2**LINE_AW];

  // Half-line write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (hen_i[0]) mem_q[widx_i][BEAT_BITS-1:0] <= wline_i[BEAT_BITS-1:0];
      if (hen_i[1]) mem_q[widx_i][LINE_BITS-1:BEAT_BITS] <= wline_i[LINE_BITS-1:BEAT_BITS];
    end
  end

  assign rline_o = mem_q[ridx_i];

endmodule

// File: rtl/cache_bus_mem.sv
// Memory-side responder for the 2-beat cache line bus. Independent read and
// write FSMs share one line array; all bus outputs come straight from flops.
module cache_bus_mem
  import cache_bus_pkg::*;
#(
  parameter int LINE_AW    = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic            clock,
  input  logic            reset,
  cache_bus_mem_if.slave  io_cache_bus,
  output r_state_e        r_state_o,
  output w_state_e        w_state_o
);

  // The wait state counts down to zero inclusive, so it is loaded with one
  // less than the number of wait cycles; zero latency skips the wait state.
  localparam logic [3:0] CNT_LOAD = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

  r_state_e             r_state_q;
  logic [3:0]           cnt_q;
  logic [LINE_AW-1:0]   r_idx_q;
  logic [LINE_BITS-1:0] rbuf_q;
  logic [BEAT_BITS-1:0] rdata_q;
  logic                 r_ready_q;
  logic                 rlast_q;

  w_state_e             w_state_q;
  logic [LINE_AW-1:0]   w_idx_q;
  logic [BEAT_BITS-1:0] wlow_q;
  logic                 w_ready_q;
  logic                 b_valid_q;

  logic [LINE_AW-1:0]   r_idx_in;
  logic [LINE_AW-1:0]   w_idx_in;
  logic [LINE_AW-1:0]   rd_idx;
  logic [LINE_BITS-1:0] rd_line;
  logic                 mem_we;
  logic [1:0]           mem_hen;
  logic [LINE_AW-1:0]   mem_widx;
  logic [LINE_BITS-1:0] mem_wline;

  assign r_idx_in = LINE_AW'(line_of(io_cache_bus.r_bits_raddr));
  assign w_idx_in = LINE_AW'(line_of(io_cache_bus.w_bits_waddr));

  // Only a zero-latency capture happens in R_IDLE, before the index is latched.
  assign rd_idx = (r_state_q == R_IDLE) ? r_idx_in : r_idx_q;

  cache_bus_mem_array #(.LINE_AW(LINE_AW)) u_array (
    .clk_i   (clock),
    .we_i    (mem_we),
    .hen_i   (mem_hen),
    .widx_i  (mem_widx),
    .wline_i (mem_wline),
    .ridx_i  (rd_idx),
    .rline_o (rd_line)
  );

  // Array write port: single-beat writes touch the low half only.
  always_comb begin
    mem_we    = 1'b0;
    mem_hen   = 2'b00;
    mem_widx  = w_idx_in;
    mem_wline = {BEAT_BITS'(0), io_cache_bus.w_bits_wdata};
    case (w_state_q)
      W_IDLE: begin
        if (io_cache_bus.w_valid && io_cache_bus.w_bits_wlast) begin
          mem_we  = 1'b1;
          mem_hen = 2'b01;
        end
      end
      W_BEAT1: begin
        if (io_cache_bus.w_valid) begin
          mem_we    = 1'b1;
          mem_hen   = 2'b11;
          mem_widx  = w_idx_q;
          mem_wline = {io_cache_bus.w_bits_wdata, wlow_q};
        end
      end
      default: ;
    endcase
  end

  // Read FSM: wait out the latency, capture the line, then stream two beats.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      cnt_q     <= '0;
      r_idx_q   <= '0;
      rbuf_q    <= '0;
      rdata_q   <= '0;
      r_ready_q <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (io_cache_bus.r_valid) begin
            r_idx_q <= r_idx_in;
            cnt_q   <= CNT_LOAD;
            if (RD_LATENCY == 0) begin
              rbuf_q    <= rd_line;
              rdata_q   <= rd_line[BEAT_BITS-1:0];
              r_ready_q <= 1'b1;
              r_state_q <= R_BEAT0;
            end else begin
              r_state_q <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (!io_cache_bus.r_valid) begin
            r_state_q <= R_IDLE;
          end else if (cnt_q == 4'd0) begin
            rbuf_q    <= rd_line;
            rdata_q   <= rd_line[BEAT_BITS-1:0];
            r_ready_q <= 1'b1;
            r_state_q <= R_BEAT0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        R_BEAT0: begin
          if (!io_cache_bus.r_valid) begin
            r_state_q <= R_IDLE;
            r_ready_q <= 1'b0;
            rdata_q   <= '0;
          end else begin
            r_state_q <= R_BEAT1;
            rdata_q   <= rbuf_q[LINE_BITS-1:BEAT_BITS];
            rlast_q   <= 1'b1;
          end
        end
        default: begin
          // R_BEAT1: either the last beat fired or the request was dropped.
          r_state_q <= R_IDLE;
          r_ready_q <= 1'b0;
          rlast_q   <= 1'b0;
          rdata_q   <= '0;
        end
      endcase
    end
  end

  // Write FSM: collect beats, commit through the array port, then hold B.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      wlow_q    <= '0;
      w_ready_q <= 1'b1;
      b_valid_q <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (io_cache_bus.w_valid) begin
            if (io_cache_bus.w_bits_wlast) begin
              w_state_q <= W_RESP;
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
            end else begin
              w_idx_q   <= w_idx_in;
              wlow_q    <= io_cache_bus.w_bits_wdata;
              w_state_q <= W_BEAT1;
            end
          end
        end
        W_BEAT1: begin
          if (io_cache_bus.w_valid) begin
            w_state_q <= W_RESP;
            w_ready_q <= 1'b0;
            b_valid_q <= 1'b1;
          end
        end
        W_RESP: begin
          if (io_cache_bus.b_ready) begin
            w_state_q <= W_IDLE;
            w_ready_q <= 1'b1;
            b_valid_q <= 1'b0;
          end
        end
        default: begin
          w_state_q <= W_IDLE;
          w_ready_q <= 1'b1;
          b_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io_cache_bus.r_ready      = r_ready_q;
  assign io_cache_bus.r_bits_rdata = rdata_q;
  assign io_cache_bus.r_bits_rlast = rlast_q;
  assign io_cache_bus.w_ready      = w_ready_q;
  assign io_cache_bus.b_valid      = b_valid_q;
  assign r_state_o                 = r_state_q;
  assign w_state_o                 = w_state_q;

endmodule

// File: tb/tb_cache_bus_mem.sv
// Bench for cache_bus_mem: dut0 uses RD_LATENCY=2, dut1 uses RD_LATENCY=0.
module tb_cache_bus_mem;
  import cache_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUTs ----------------
  cache_bus_mem_if bus0();
  cache_bus_mem_if bus1();

  logic [1:0]  r_valid = '0, w_valid = '0, w_last = '0, b_ready = '0;
  logic [63:0] raddr [2];
  logic [63:0] waddr [2];
  logic [63:0] wdata [2];
  logic [1:0]  r_ready, r_last, w_ready, b_valid;
  logic [63:0] rdata [2];
  r_state_e    rst0, rst1;
  w_state_e    wst0, wst1;

  assign bus0.r_valid = r_valid[0];      assign bus1.r_valid = r_valid[1];
  assign bus0.r_bits_raddr = raddr[0];   assign bus1.r_bits_raddr = raddr[1];
  assign bus0.w_valid = w_valid[0];      assign bus1.w_valid = w_valid[1];
  assign bus0.w_bits_waddr = waddr[0];   assign bus1.w_bits_waddr = waddr[1];
  assign bus0.w_bits_wdata = wdata[0];   assign bus1.w_bits_wdata = wdata[1];
  assign bus0.w_bits_wlast = w_last[0];  assign bus1.w_bits_wlast = w_last[1];
  assign bus0.b_ready = b_ready[0];      assign bus1.b_ready = b_ready[1];
  assign r_ready = {bus1.r_ready, bus0.r_ready};
  assign r_last  = {bus1.r_bits_rlast, bus0.r_bits_rlast};
  assign w_ready = {bus1.w_ready, bus0.w_ready};
  assign b_valid = {bus1.b_valid, bus0.b_valid};
  assign rdata[0] = bus0.r_bits_rdata;
  assign rdata[1] = bus1.r_bits_rdata;

  cache_bus_mem #(.LINE_AW(10), .RD_LATENCY(2)) dut0 (
    .clock(clk), .reset(rst_n), .io_cache_bus(bus0), .r_state_o(rst0), .w_state_o(wst0)
  );
  cache_bus_mem #(.LINE_AW(10), .RD_LATENCY(0)) dut1 (
    .clock(clk), .reset(rst_n), .io_cache_bus(bus1), .r_state_o(rst1), .w_state_o(wst1)
  );

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int s, input logic [64:0] e);
    if (s == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Monitor: pop and compare on every R beat; rlast must never lead r_ready.
  task automatic mon_beat(input int s);
    logic [64:0] e;
    if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL dut%0d_unexpected_beat: got rlast=%b rdata=%h, required no beat", s, r_last[s], rdata[s]);
      return;
    end
    e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    check($sformatf("dut%0d_rd_beat", s), 128'({r_last[s], rdata[s]}), 128'(e));
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      check($sformatf("dut%0d_rlast_without_ready", s), 128'(r_last[s] & ~r_ready[s]), 128'(0));
      if (r_valid[s] && r_ready[s]) mon_beat(s);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_read(input int s, input logic [63:0] addr, input logic [127:0] line, input int lat);
    int t0, b0, b1;
    b0 = -1;
    b1 = -1;
    push_exp(s, {1'b0, line[63:0]});
    push_exp(s, {1'b1, line[127:64]});
    @(posedge clk); #1;
    t0 = cyc;
    r_valid[s] = 1'b1;
    raddr[s]   = addr;
    for (int i = 0; i < 40 && b1 < 0; i++) begin
      @(negedge clk);
      if (r_valid[s] && r_ready[s]) begin
        if (r_last[s]) b1 = cyc;
        else           b0 = cyc;
      end
    end
    @(posedge clk); #1;
    r_valid[s] = 1'b0;
    check_int($sformatf("dut%0d_rd_beat0_cycle", s), b0 - t0, 1 + lat);
    check_int($sformatf("dut%0d_rd_beat1_cycle", s), b1 - t0, 2 + lat);
  endtask

  task automatic b_handshake(input int s);
    int nb;
    nb = $urandom_range(0, 2);
    repeat (nb) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("dut%0d_b_hold", s), 128'(b_valid[s]), 128'(1));
    end
    @(posedge clk); #1;
    b_ready[s] = 1'b1;
    @(negedge clk);
    check($sformatf("dut%0d_b_valid_at_ready", s), 128'(b_valid[s]), 128'(1));
    @(posedge clk); #1;
    b_ready[s] = 1'b0;
    @(negedge clk);
    check($sformatf("dut%0d_b_drop", s), 128'(b_valid[s]), 128'(0));
    check($sformatf("dut%0d_w_ready_back", s), 128'(w_ready[s]), 128'(1));
  endtask

  task automatic do_write(input int s, input logic [63:0] addr, input logic [63:0] lo,
                          input logic [63:0] hi, input bit single, input bit hold_b);
    @(posedge clk); #1;
    w_valid[s] = 1'b1;
    waddr[s]   = addr;
    wdata[s]   = lo;
    w_last[s]  = single;
    @(negedge clk);
    check($sformatf("dut%0d_w_ready_beat0", s), 128'(w_ready[s]), 128'(1));
    check($sformatf("dut%0d_b_valid_beat0", s), 128'(b_valid[s]), 128'(0));
    if (!single) begin
      @(posedge clk); #1;
      wdata[s]  = hi;
      w_last[s] = 1'b1;
      @(negedge clk);
      check($sformatf("dut%0d_w_ready_beat1", s), 128'(w_ready[s]), 128'(1));
      check($sformatf("dut%0d_b_valid_beat1", s), 128'(b_valid[s]), 128'(0));
    end
    @(posedge clk); #1;
    w_valid[s] = 1'b0;
    w_last[s]  = 1'b0;
    @(negedge clk);
    check($sformatf("dut%0d_b_valid_rise", s), 128'(b_valid[s]), 128'(1));
    check($sformatf("dut%0d_w_ready_resp", s), 128'(w_ready[s]), 128'(0));
    if (!hold_b) b_handshake(s);
  endtask

  task automatic check_reset_outs(input string tag);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("%s_dut%0d_r_ready", tag, s), 128'(r_ready[s]), 128'(0));
      check($sformatf("%s_dut%0d_rlast", tag, s), 128'(r_last[s]), 128'(0));
      check($sformatf("%s_dut%0d_rdata", tag, s), 128'(rdata[s]), 128'(0));
      check($sformatf("%s_dut%0d_w_ready", tag, s), 128'(w_ready[s]), 128'(1));
      check($sformatf("%s_dut%0d_b_valid", tag, s), 128'(b_valid[s]), 128'(0));
    end
    check($sformatf("%s_dut0_r_state", tag), 128'(rst0), 128'(R_IDLE));
    check($sformatf("%s_dut0_w_state", tag), 128'(wst0), 128'(W_IDLE));
  endtask

  // ---------------- stimulus ----------------
  localparam logic [63:0] L80_LO = 64'h1111_2222_3333_4444;
  localparam logic [63:0] L80_HI = 64'hAAAA_BBBB_CCCC_DDDD;

  initial begin
    logic [127:0] l40, l80b, l10_old, l10_new, l30;
    for (int s = 0; s < 2; s++) begin
      raddr[s] = '0; waddr[s] = '0; wdata[s] = '0;
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outs("reset_init");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write-back of line 0x80, then refill via offset address 0x808.
    do_write(0, 64'h800, L80_LO, L80_HI, 1'b0, 1'b0);
    do_read(0, 64'h808, {L80_HI, L80_LO}, 2);
    // Upper address bits alias onto the same line.
    do_read(0, 64'h4800, {L80_HI, L80_LO}, 2);

    // Concurrent refill of 0x400 and write-back to 0x800.
    l40  = {64'h0400_0000_0000_0002, 64'h0400_0000_0000_0001};
    l80b = {64'hA5A5_A5A5_0000_0800, 64'h5A5A_5A5A_0000_0800};
    do_write(0, 64'h400, l40[63:0], l40[127:64], 1'b0, 1'b0);
    fork
      do_read(0, 64'h400, l40, 2);
      do_write(0, 64'h800, l80b[63:0], l80b[127:64], 1'b0, 1'b0);
    join
    do_read(0, 64'h800, l80b, 2);
    do_read(0, 64'h400, l40, 2);

    // Same-line race: commit edge of the write equals capture edge of the read.
    l10_old = {64'hDEAD_0000_0000_0010, 64'hBEEF_0000_0000_0010};
    l10_new = {64'h0123_0000_0000_1010, 64'h4567_0000_0000_1010};
    do_write(0, 64'h100, l10_old[63:0], l10_old[127:64], 1'b0, 1'b0);
    fork
      do_read(0, 64'h100, l10_old, 2);
      begin
        @(posedge clk);
        do_write(0, 64'h100, l10_new[63:0], l10_new[127:64], 1'b0, 1'b0);
      end
    join
    do_read(0, 64'h100, l10_new, 2);

    // Single-beat write keeps the high half.
    do_write(0, 64'h200, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    do_write(0, 64'h200, 64'h5555_6666_7777_8888, 64'h0, 1'b1, 1'b0);
    do_read(0, 64'h200, {64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_6666_7777_8888}, 2);

    // Zero-latency build: beats at T+1 and T+2, back-to-back reads.
    do_write(1, 64'h500, 64'h0000_0500_0000_0001, 64'h0000_0500_0000_0002, 1'b0, 1'b0);
    do_write(1, 64'h510, 64'h0000_0510_0000_0001, 64'h0000_0510_0000_0002, 1'b0, 1'b0);
    do_read(1, 64'h500, {64'h0000_0500_0000_0002, 64'h0000_0500_0000_0001}, 0);
    do_read(1, 64'h510, {64'h0000_0510_0000_0002, 64'h0000_0510_0000_0001}, 0);

    // Aborted refill: r_valid dropped in R_WAIT, no beats may appear.
    @(posedge clk); #1;
    r_valid[0] = 1'b1;
    raddr[0]   = 64'h400;
    @(posedge clk); #1;
    r_valid[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("abort_no_beat", 128'(r_ready[0]), 128'(0));
    end
    do_read(0, 64'h400, l40, 2);

    // Reset during R_WAIT.
    @(posedge clk); #1;
    r_valid[0] = 1'b1;
    raddr[0]   = 64'h400;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset_r_wait", 128'(rst0), 128'(R_WAIT));
    #1 rst_n = 1'b0;
    #1 check_reset_outs("reset_r_wait");
    r_valid[0] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    do_read(0, 64'h808, l80b, 2);

    // Reset during W_RESP: response dropped, committed line kept.
    l30 = {64'h3030_3030_3030_3031, 64'h3030_3030_3030_3030};
    do_write(0, 64'h300, l30[63:0], l30[127:64], 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_reset_outs("reset_w_resp");
    @(posedge clk); #1 rst_n = 1'b1;
    do_read(0, 64'h300, l30, 2);
    do_write(0, 64'h300, 64'h0, 64'h1, 1'b0, 1'b0);
    do_read(0, 64'h300, {64'h1, 64'h0}, 2);

    repeat (3) @(posedge clk);
    check_int("exp_q0_drained", exp_q0.size(), 0);
    check_int("exp_q1_drained", exp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog for a stuck handshake.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got no completion by %0t, required completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
